// File: rtl/d2_uop_sequencer_if.sv
// Decode-stage-2 sequencer bundle: decode/control-store inputs and sequenced control outputs.
interface d2_uop_sequencer_if #(
  parameter int unsigned UADDR_W = 7
);
  logic               D2_V;
  logic               STALL_IN;
  logic [7:0]         decode_address;
  logic               opcode_size;
  logic [UADDR_W-1:0] CS_NEXT_UADDR;
  logic               CS_UOP_STALL;
  logic               CS_JMP_STALL;
  logic               JMP_RESOLVED;
  logic               INT_REQ;
  logic               FLUSH;
  logic               WB_REPNE_TERMINATE_ALL;
  logic [7:0]         CS_ADDR;
  logic               CS_OP_SIZE;
  logic               D2_V_OUT;
  logic               D1_STALL_OUT;
  logic               INT_ACK;
  logic               UOP_OVF;
  logic [1:0]         SEQ_STATE;

  modport master (
    output D2_V, STALL_IN, decode_address, opcode_size, CS_NEXT_UADDR, CS_UOP_STALL,
           CS_JMP_STALL, JMP_RESOLVED, INT_REQ, FLUSH, WB_REPNE_TERMINATE_ALL,
    input  CS_ADDR, CS_OP_SIZE, D2_V_OUT, D1_STALL_OUT, INT_ACK, UOP_OVF, SEQ_STATE
  );

  modport slave (
    input  D2_V, STALL_IN, decode_address, opcode_size, CS_NEXT_UADDR, CS_UOP_STALL,
           CS_JMP_STALL, JMP_RESOLVED, INT_REQ, FLUSH, WB_REPNE_TERMINATE_ALL,
    output CS_ADDR, CS_OP_SIZE, D2_V_OUT, D1_STALL_OUT, INT_ACK, UOP_OVF, SEQ_STATE
  );
endinterface

// File: rtl/d2_uop_sequencer.sv
// Microcode control-store address sequencer for decode stage 2: entry address, uop chain,
// interrupt entry and jump wait, with decode-stage-1 hold and flush/REPNE kill.
module d2_uop_sequencer #(
  parameter int unsigned UADDR_W   = 7,
  parameter int unsigned MAX_UOPS  = 15,
  parameter logic [7:0]  INT_UADDR = 8'h80
) (
  input logic               clk,
  input logic               reset,
  d2_uop_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    StDec   = 2'b00,
    StUop   = 2'b01,
    StInt   = 2'b10,
    StJwait = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [UADDR_W-1:0] next_uaddr_q, next_uaddr_d;
  logic [3:0]         uop_cnt_q, uop_cnt_d;
  logic               ovf_q, ovf_d;

  logic       kill;
  logic [7:0] cs_addr;
  logic       op_size, v_out, d1_stall, int_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StDec;
      next_uaddr_q <= '0;
      uop_cnt_q    <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_uaddr_q <= next_uaddr_d;
      uop_cnt_q    <= uop_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    next_uaddr_d = next_uaddr_q;
    uop_cnt_d    = uop_cnt_q;
    ovf_d        = ovf_q;
    cs_addr      = bus.decode_address;
    op_size      = 1'b0;
    v_out        = 1'b0;
    d1_stall     = 1'b0;
    int_ack      = 1'b0;
    kill         = bus.FLUSH | bus.WB_REPNE_TERMINATE_ALL;

    unique case (state_q)
      StDec: begin
        op_size = bus.opcode_size;
        // An instruction that opens the interrupt entry is not issued.
        v_out   = bus.D2_V & ~bus.INT_REQ;
      end
      StUop: begin
        cs_addr  = 8'(next_uaddr_q);
        v_out    = 1'b1;
        d1_stall = 1'b1;
      end
      StInt: begin
        cs_addr  = INT_UADDR;
        v_out    = 1'b1;
        d1_stall = 1'b1;
      end
      StJwait: d1_stall = 1'b1;
      default: ;
    endcase

    if (kill) begin
      v_out        = 1'b0;
      state_d      = StDec;
      uop_cnt_d    = '0;
      next_uaddr_d = '0;
    end else if (!bus.STALL_IN) begin
      unique case (state_q)
        StDec: begin
          if (bus.D2_V) begin
            if (bus.INT_REQ) begin
              state_d = StInt;
            end else if (bus.CS_UOP_STALL) begin
              state_d      = StUop;
              next_uaddr_d = bus.CS_NEXT_UADDR;
              uop_cnt_d    = 4'd1;
            end else if (bus.CS_JMP_STALL) begin
              state_d = StJwait;
            end
          end
        end
        StInt: begin
          int_ack = 1'b1;
          if (bus.CS_UOP_STALL) begin
            state_d      = StUop;
            next_uaddr_d = bus.CS_NEXT_UADDR;
            uop_cnt_d    = 4'd1;
          end else begin
            state_d = StDec;
          end
        end
        StUop: begin
          if (bus.CS_UOP_STALL) begin
            next_uaddr_d = bus.CS_NEXT_UADDR;
            if (uop_cnt_q == 4'(MAX_UOPS)) ovf_d = 1'b1;
            if (uop_cnt_q != 4'hF) uop_cnt_d = uop_cnt_q + 4'd1;
          end else begin
            state_d   = bus.CS_JMP_STALL ? StJwait : StDec;
            uop_cnt_d = '0;
          end
        end
        StJwait: if (bus.JMP_RESOLVED) state_d = StDec;
        default: ;
      endcase
    end
  end

  assign bus.CS_ADDR      = cs_addr;
  assign bus.CS_OP_SIZE   = op_size;
  assign bus.D2_V_OUT     = v_out & reset;
  assign bus.D1_STALL_OUT = d1_stall & reset;
  assign bus.INT_ACK      = int_ack;
  assign bus.UOP_OVF      = ovf_q;
  assign bus.SEQ_STATE    = state_q;

endmodule

// File: tb/tb_d2_uop_sequencer.sv
// Directed and randomized checks of d2_uop_sequencer against a cycle-level behavioural model.
module tb_d2_uop_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  d2_uop_sequencer_if #(.UADDR_W(7)) bus ();

  d2_uop_sequencer #(
    .UADDR_W  (7),
    .MAX_UOPS (15),
    .INT_UADDR(8'h80)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 decode, 1 micro-op chain, 2 interrupt entry, 3 jump wait.
  int m_mode = 0;
  int m_next = 0;
  int m_cnt  = 0;
  bit m_ovf  = 0;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit killed();
    return bus.FLUSH || bus.WB_REPNE_TERMINATE_ALL;
  endfunction

  task automatic check_all();
    int  e_addr, e_v, e_d1, e_ack;
    int  e_size;
    e_addr = bus.decode_address;
    e_size = -1;
    e_v    = 0;
    e_d1   = 1;
    e_ack  = 0;
    case (m_mode)
      0: begin
        e_size = bus.opcode_size;
        e_v    = bus.D2_V && !bus.INT_REQ;
        e_d1   = 0;
      end
      1: begin e_addr = m_next; e_size = 0; e_v = 1; end
      2: begin
        e_addr = 8'h80; e_size = 0; e_v = 1;
        e_ack  = !killed() && !bus.STALL_IN;
      end
      default: ;
    endcase
    if (killed()) e_v = 0;
    cmp("cs_addr", bus.CS_ADDR, 8'(e_addr));
    if (e_size >= 0) cmp("cs_op_size", 8'(bus.CS_OP_SIZE), 8'(e_size));
    cmp("d2_v_out", 8'(bus.D2_V_OUT), 8'(e_v));
    cmp("d1_stall_out", 8'(bus.D1_STALL_OUT), 8'(e_d1));
    cmp("int_ack", 8'(bus.INT_ACK), 8'(e_ack));
    cmp("uop_ovf", 8'(bus.UOP_OVF), 8'(m_ovf));
    cmp("seq_state", 8'(bus.SEQ_STATE), 8'(m_mode));
  endtask

  task automatic model_step();
    if (killed()) begin
      m_mode = 0; m_cnt = 0; m_next = 0;
    end else if (!bus.STALL_IN) begin
      case (m_mode)
        0: if (bus.D2_V) begin
          if (bus.INT_REQ) m_mode = 2;
          else if (bus.CS_UOP_STALL) begin m_mode = 1; m_next = bus.CS_NEXT_UADDR; m_cnt = 1; end
          else if (bus.CS_JMP_STALL) m_mode = 3;
        end
        2: if (bus.CS_UOP_STALL) begin m_mode = 1; m_next = bus.CS_NEXT_UADDR; m_cnt = 1; end
           else m_mode = 0;
        1: if (bus.CS_UOP_STALL) begin
          // Runaway once the chain keeps going past MAX_UOPS (15) uops.
          if (m_cnt == 15) m_ovf = 1;
          m_next = bus.CS_NEXT_UADDR;
          m_cnt  = (m_cnt < 15) ? m_cnt + 1 : 15;
        end else begin
          m_mode = bus.CS_JMP_STALL ? 3 : 0;
          m_cnt  = 0;
        end
        3: if (bus.JMP_RESOLVED) m_mode = 0;
        default: ;
      endcase
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.D2_V = 0; bus.STALL_IN = 0; bus.decode_address = 8'h00; bus.opcode_size = 0;
    bus.CS_NEXT_UADDR = 7'h00; bus.CS_UOP_STALL = 0; bus.CS_JMP_STALL = 0;
    bus.JMP_RESOLVED = 0; bus.INT_REQ = 0; bus.FLUSH = 0; bus.WB_REPNE_TERMINATE_ALL = 0;
  endtask

  task automatic check_in_reset();
    cmp("rst_d2_v_out", 8'(bus.D2_V_OUT), 8'h0);
    cmp("rst_d1_stall", 8'(bus.D1_STALL_OUT), 8'h0);
    cmp("rst_state", 8'(bus.SEQ_STATE), 8'h0);
    cmp("rst_int_ack", 8'(bus.INT_ACK), 8'h0);
    cmp("rst_uop_ovf", 8'(bus.UOP_OVF), 8'h0);
    m_mode = 0; m_next = 0; m_cnt = 0; m_ovf = 0;
  endtask

  initial begin
    idle();
    bus.D2_V = 1;
    #2;
    check_in_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single-uop instruction stays in decode.
    bus.D2_V = 1; bus.decode_address = 8'h2A; bus.opcode_size = 1;
    cyc();
    cyc();

    // Three-uop chain 10 -> 41 -> 42.
    bus.decode_address = 8'h10; bus.opcode_size = 0;
    bus.CS_UOP_STALL = 1; bus.CS_NEXT_UADDR = 7'h41;
    cyc();
    bus.CS_NEXT_UADDR = 7'h42;
    cyc();
    bus.CS_UOP_STALL = 0;
    cyc();
    bus.D2_V = 0;
    cyc();

    // Downstream stall holds the chain at 41.
    bus.D2_V = 1; bus.CS_UOP_STALL = 1; bus.CS_NEXT_UADDR = 7'h41;
    cyc();
    bus.STALL_IN = 1; bus.CS_NEXT_UADDR = 7'h55;
    cyc();
    cyc();
    bus.STALL_IN = 0; bus.CS_UOP_STALL = 0;
    cyc();
    bus.D2_V = 0;
    cyc();

    // Interrupt taken in decode; acknowledged once.
    bus.D2_V = 1; bus.INT_REQ = 1; bus.decode_address = 8'h33;
    cyc();
    cyc();
    bus.INT_REQ = 0;
    cyc();

    // Interrupt raised mid-chain waits for the return to decode.
    bus.CS_UOP_STALL = 1; bus.CS_NEXT_UADDR = 7'h20;
    cyc();
    bus.INT_REQ = 1; bus.CS_NEXT_UADDR = 7'h21;
    cyc();
    bus.CS_UOP_STALL = 0;
    cyc();
    cyc();
    cyc();
    bus.INT_REQ = 0; bus.D2_V = 0;
    cyc();

    // Flush during a stalled chain kills issue immediately.
    bus.D2_V = 1; bus.CS_UOP_STALL = 1; bus.CS_NEXT_UADDR = 7'h41; bus.decode_address = 8'h77;
    cyc();
    bus.STALL_IN = 1; bus.FLUSH = 1;
    cyc();
    bus.STALL_IN = 0; bus.FLUSH = 0; bus.CS_UOP_STALL = 0;
    cyc();

    // Jump wait released by resolve, then REPNE terminate during a jump wait.
    bus.CS_JMP_STALL = 1;
    cyc();
    bus.CS_JMP_STALL = 0;
    cyc();
    bus.JMP_RESOLVED = 1;
    cyc();
    bus.JMP_RESOLVED = 0; bus.CS_JMP_STALL = 1;
    cyc();
    bus.CS_JMP_STALL = 0; bus.JMP_RESOLVED = 1; bus.WB_REPNE_TERMINATE_ALL = 1;
    cyc();
    bus.JMP_RESOLVED = 0; bus.WB_REPNE_TERMINATE_ALL = 0; bus.D2_V = 0;
    cyc();

    // Runaway chain: sixteen consecutive follow-on uops.
    bus.D2_V = 1; bus.CS_UOP_STALL = 1;
    for (int i = 0; i < 17; i++) begin
      bus.CS_NEXT_UADDR = 7'(i + 1);
      cyc();
    end
    bus.CS_UOP_STALL = 0;
    cyc();
    bus.D2_V = 0;
    cyc();
    cyc();

    // Asynchronous reset mid-chain, then no leftover uop on release.
    bus.D2_V = 1; bus.CS_UOP_STALL = 1; bus.CS_NEXT_UADDR = 7'h3C;
    cyc();
    cyc();
    reset = 1'b0;
    #2;
    check_in_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    cyc();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.D2_V = ($urandom_range(0, 3) != 0);
      bus.decode_address = 8'($urandom_range(0, 255));
      bus.opcode_size = 1'($urandom_range(0, 1));
      bus.CS_NEXT_UADDR = 7'($urandom_range(0, 127));
      bus.CS_UOP_STALL = ($urandom_range(0, 9) < 3);
      bus.CS_JMP_STALL = ($urandom_range(0, 9) < 2);
      bus.JMP_RESOLVED = ($urandom_range(0, 9) < 3);
      bus.INT_REQ = ($urandom_range(0, 9) < 1);
      bus.FLUSH = ($urandom_range(0, 19) < 1);
      bus.WB_REPNE_TERMINATE_ALL = ($urandom_range(0, 29) < 1);
      bus.STALL_IN = ($urandom_range(0, 19) < 3);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
